// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction-fetch bus responder.
package ibex_pkg;

  localparam int unsigned NumReqsMin = 1;
  localparam int unsigned NumReqsMax = 4;
  localparam int unsigned BusW       = 32;

  typedef struct packed {
    logic [BusW-1:0] rdata;
    logic            err;
  } instr_rsp_t;

  // Word offset of a byte address from the memory base; below-base addresses wrap high.
  function automatic logic [BusW-1:0] word_offset(input logic [BusW-1:0] addr,
                                                  input logic [BusW-1:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/ibex_instr_rsp_queue.sv
// In-order response queue: circular buffer with push/pop and full/empty flags.
module ibex_instr_rsp_queue
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  instr_rsp_t wdata_i,
  input  logic       pop_i,
  output instr_rsp_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  instr_rsp_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  PushNotFull: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  PopNotEmpty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Instruction-fetch bus responder: grants fetches against a word memory and
// returns responses strictly in grant order, bypassing the queue when idle.
module ibex_instr_bus_responder
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS     = 2,
  parameter logic [31:0] MemBase      = 32'h0000_0000,
  parameter int unsigned MemSizeWords = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            instr_req_i,
  input  logic [31:0]                     instr_addr_i,
  output logic                            instr_gnt_o,
  output logic                            instr_rvalid_o,
  output logic [31:0]                     instr_rdata_o,
  output logic                            instr_err_o,
  input  logic                            rsp_stall_i,
  output logic                            mem_req_o,
  output logic [$clog2(MemSizeWords)-1:0] mem_addr_o,
  input  logic [31:0]                     mem_rdata_i,
  output logic [$clog2(NUM_REQS+1)-1:0]   outstanding_o
);

  localparam int unsigned CntW  = $clog2(NUM_REQS + 1);
  localparam int unsigned AddrW = $clog2(MemSizeWords);

  logic [CntW-1:0] cnt_q;
  logic            cap_q, cap_in_range_q;
  logic [31:0]     word_idx;
  logic            in_range;
  instr_rsp_t      new_entry, q_head;
  logic            q_full, q_empty, q_push, q_pop, bypass;

  // Address decode; reset gating keeps the grant low while rst_ni is asserted.
  assign word_idx    = word_offset(instr_addr_i, MemBase);
  assign in_range    = (word_idx < 32'(MemSizeWords));
  assign instr_gnt_o = instr_req_i & rst_ni & (cnt_q < CntW'(NUM_REQS));
  assign mem_req_o   = instr_gnt_o & in_range;
  assign mem_addr_o  = word_idx[AddrW-1:0];

  // Entry formed the cycle after the grant, when memory data is valid.
  always_comb begin
    new_entry       = '0;
    new_entry.rdata = cap_in_range_q ? mem_rdata_i : 32'h0;
    new_entry.err   = ~cap_in_range_q;
  end

  assign bypass = cap_q & q_empty & ~rsp_stall_i;
  assign q_push = cap_q & ~bypass;
  assign q_pop  = ~q_empty & ~rsp_stall_i;

  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    if (q_pop) begin
      instr_rvalid_o = 1'b1;
      instr_rdata_o  = q_head.rdata;
      instr_err_o    = q_head.err;
    end else if (bypass) begin
      instr_rvalid_o = 1'b1;
      instr_rdata_o  = new_entry.rdata;
      instr_err_o    = new_entry.err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      cap_q          <= 1'b0;
      cap_in_range_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_q + CntW'(instr_gnt_o) - CntW'(instr_rvalid_o);
      cap_q          <= instr_gnt_o;
      cap_in_range_q <= in_range;
    end
  end

  assign outstanding_o = cnt_q;

  ibex_instr_rsp_queue #(
    .Depth (NUM_REQS)
  ) u_rsp_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (q_push),
    .wdata_i (new_entry),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  NumReqsLegal: assert property (@(posedge clk_i)
    (NUM_REQS >= NumReqsMin) && (NUM_REQS <= NumReqsMax));
  CntBound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt_q <= CntW'(NUM_REQS));
  RvalidNeedsCnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_o |-> (cnt_q != '0));
  NoPushFull: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(q_push && q_full));

endmodule

// File: doc/ibex_instr_bus_responder.md
IBEX_INSTR_BUS_RESPONDER -- requirements
Module: ibex_instr_bus_responder

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, maximum outstanding granted-but-unanswered requests (legal 1..4).
REQ-002 SHALL have parameter MemBase, default 32'h0000_0000, byte base address of backing memory (word aligned).
REQ-003 SHALL have parameter MemSizeWords, default 1024, backing memory depth in 32-bit words (power of two).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock; rst_ni  input  1  asynchronous reset, active low.
REQ-005 SHALL have instr_req_i  input  1  fetch request valid.
REQ-006 SHALL have instr_addr_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have instr_gnt_o  output  1  request accepted this cycle.
REQ-008 SHALL have instr_rvalid_o  output  1  response valid.
REQ-009 SHALL have instr_rdata_o  output  32  response word.
REQ-010 SHALL have instr_err_o  output  1  response error.
REQ-011 SHALL have rsp_stall_i  input  1  when high, no response is presented.
REQ-012 SHALL have mem_req_o  output  1  backing memory read strobe.
REQ-013 SHALL have mem_addr_o  output  $clog2(MemSizeWords)  word index.
REQ-014 SHALL have mem_rdata_i  input  32  read data, valid the cycle after mem_req_o.
REQ-015 SHALL have outstanding_o  output  $clog2(NUM_REQS+1)  current outstanding count.

Function
REQ-016 instr_gnt_o SHALL equal instr_req_i & (outstanding < NUM_REQS), combinationally; no grant when count equals NUM_REQS.
REQ-017 In-range: (instr_addr_i - MemBase) >> 2 < MemSizeWords, unsigned 32-bit subtraction; addresses below MemBase wrap high and are therefore out of range.
REQ-018 mem_req_o SHALL equal instr_gnt_o & in-range; mem_addr_o SHALL equal (instr_addr_i - MemBase) >> 2, truncated to width.
REQ-019 For a grant in cycle T, a response entry SHALL be formed in cycle T+1: rdata = mem_rdata_i if in-range else 32'h0, err = ~in-range.
REQ-020 Responses SHALL be returned strictly in grant order; no response is ever dropped or duplicated.
REQ-021 Bypass: if the response queue is empty and rsp_stall_i is low in T+1, the entry SHALL be driven on instr_rvalid_o/rdata/err in T+1 (1-cycle minimum latency) and not enqueued.
REQ-022 Otherwise the entry SHALL be pushed into a NUM_REQS-deep in-order queue; the queue head SHALL be presented whenever rsp_stall_i is low and pops in that cycle.
REQ-023 A response SHALL never be presented in the same cycle as its own grant.
REQ-024 When instr_rvalid_o is low, instr_rdata_o and instr_err_o SHALL be 0.
REQ-025 Outstanding counter: +1 on grant, -1 on rvalid, unchanged when both or neither; SHALL never exceed NUM_REQS nor underflow.
REQ-026 Queue full and new entry in same cycle: an entry is popped only when rsp_stall_i is low; push while full cannot occur because of REQ-016 (assertion).
REQ-027 Grant and response in the same cycle at count NUM_REQS: no grant that cycle (count is evaluated before the decrement).

Reset
REQ-028 On rst_ni low, asynchronously: outstanding 0, queue empty, pending T+1 capture cancelled.
REQ-029 During and after reset: instr_gnt_o, instr_rvalid_o, mem_req_o 0; rdata/err 0; outstanding_o 0.
REQ-030 Reset mid-transaction SHALL discard all pending responses; none appear after reset release.

Structure
REQ-031 Response entry typedef (rdata, err) and the NUM_REQS legal-range constant SHALL live in ibex_pkg.
REQ-032 The in-order queue SHALL be one sub-module, ibex_instr_rsp_queue (push/pop/full/empty, parameterised depth).
REQ-033 Assertions: no push when full; no pop when empty; outstanding <= NUM_REQS; rvalid never with count 0.

Verification
REQ-034 Single fetch: req at 0x0000_0010, stall low -> gnt in T; mem_addr_o=4; rvalid in T+1 with mem word; err=0.
REQ-035 Back-to-back, NUM_REQS=2, stall high 3 cycles: two grants; third req not granted; outstanding_o=2; on stall release two responses appear in order on consecutive cycles.
REQ-036 Out of range: MemSizeWords=1024, addr 0x0000_1000 -> gnt; mem_req_o=0; rvalid with rdata=0, err=1.
REQ-037 Below base: MemBase=0x8000_0000, addr 0x7FFF_FFFC -> err=1, rdata=0.
REQ-038 Full with simultaneous response: count=2, stall low, req high -> no grant that cycle, grant next cycle; count sequence 2,1,2.
REQ-039 Reset with 2 outstanding: assert rst_ni low mid-stall -> outputs 0 immediately; after release, no rvalid without a new grant.
